window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3.sv | 123 ++++++++++++
 tb/tb_window_3x3.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/window_3x3.sv
// window_3x3
//   Streams a raster-order image and emits every fully interior 3x3
//   neighbourhood, one cycle after its bottom-right pixel is accepted.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   pixel_in     in   DW   raster-order pixel
//   pixel_valid  in   1    pixel_in accepted this edge
//   sof          in   1    start-of-frame (only with pixel_valid)
//   win          out  9*DW registered window, tap k=3*i+j at win[9*DW-1-DW*k -: DW]
//   win_valid    out  1    one-cycle pulse per new window
//   frame_done   out  1    pulse with the last window of a frame
module window_3x3 #(
    parameter int IMG_W = 250,
    parameter int IMG_H = 125,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   pixel_in,
    input  logic            pixel_valid,
    input  logic            sof,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic            frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [9*DW-1:0] win_q;
    logic            win_valid_q, frame_done_q;
    // Two previous columns of the current window, top pixel in the MSBs.
    logic [3*DW-1:0] col_a_q, col_b_q;

    // Line buffers indexed by column: lb0 = line r-2, lb1 = line r-1.
    logic [DW-1:0]   lb0 [IMG_W];
    logic [DW-1:0]   lb1 [IMG_W];

    logic [CW-1:0]   cur_col;
    logic [RW-1:0]   cur_row;
    logic            last_col, last_row, emit, done;
    logic [DW-1:0]   top_px, mid_px;

    // sof re-labels the incoming pixel as (0,0) whatever the counters say.
    assign cur_col  = sof ? '0 : col_q;
    assign cur_row  = sof ? '0 : row_q;
    assign last_col = (cur_col == CW'(IMG_W - 1));
    assign last_row = (cur_row == RW'(IMG_H - 1));
    assign top_px   = lb0[cur_col];
    assign mid_px   = lb1[cur_col];

    // STREAM implies row >= 2; the column test keeps windows inside a line.
    assign emit = pixel_valid && !sof && (state_q == STREAM) && (cur_col >= CW'(2));
    assign done = emit && last_row && last_col;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (pixel_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (cur_row == RW'(1) && last_col) state_d = STREAM;
                STREAM:  if (last_row && last_col) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (sof) state_d = FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            col_a_q      <= '0;
            col_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= emit;
            frame_done_q <= done;
            if (pixel_valid) begin
                col_a_q <= col_b_q;
                col_b_q <= {top_px, mid_px, pixel_in};
            end
            if (emit) begin
                win_q <= {col_a_q[3*DW-1 -: DW], col_b_q[3*DW-1 -: DW], top_px,
                          col_a_q[2*DW-1 -: DW], col_b_q[2*DW-1 -: DW], mid_px,
                          col_a_q[DW-1:0],       col_b_q[DW-1:0],       pixel_in};
            end
        end
    end

    // Buffer contents are never cleared; row/col alone decide validity.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb0[cur_col] <= mid_px;
            lb1[cur_col] <= pixel_in;
        end
    end

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_3x3.sv
module tb_window_3x3;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pixel_in;
    logic        pixel_valid, sof;
    logic [71:0] win;
    logic        win_valid, frame_done;

    logic [7:0]  b_pix;
    logic        b_valid, b_sof;
    logic [71:0] b_win;
    logic        b_wv, b_fd;

    window_3x3 #(.IMG_W(5), .IMG_H(4), .DW(8)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .sof(sof), .win(win), .win_valid(win_valid), .frame_done(frame_done));

    window_3x3 u_big (
        .clk(clk), .reset(reset), .pixel_in(b_pix), .pixel_valid(b_valid),
        .sof(b_sof), .win(b_win), .win_valid(b_wv), .frame_done(b_fd));

    always #5 clk = ~clk;

    typedef struct {logic [71:0] w; logic fd;} exp_t;
    exp_t        exp_q[$];
    logic [71:0] got[$];
    int n_cmp = 0, n_err = 0;
    int seen_fd = 0, exp_fd = 0;
    int big_wv = 0, big_fd = 0;

    // Bench model: image shadow keyed by position, filled as pixels are driven.
    logic [7:0] img [4][5];
    int m_r = 0, m_c = 0;

    task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic px(input logic [7:0] d, input logic s);
        exp_t e;
        pixel_in = d; sof = s; pixel_valid = 1'b1;
        if (s) begin m_r = 0; m_c = 0; end
        img[m_r][m_c] = d;
        if (m_r >= 2 && m_c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[71-8*(3*i+j) -: 8] = img[m_r-2+i][m_c-2+j];
            e.fd = (m_r == 3 && m_c == 4);
            if (e.fd) exp_fd++;
            exp_q.push_back(e);
        end
        if (m_c == 4) begin m_c = 0; m_r = (m_r == 3) ? 0 : m_r + 1; end
        else m_c++;
        @(posedge clk); #1;
        pixel_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int base, input int npix, input logic gap, input logic first_sof);
        for (int k = 0; k < npix; k++) begin
            px(8'(base + k), first_sof && (k == 0));
            if (gap) idle(1);
        end
    endtask

    task automatic end_test(input string n, input int nwin);
        idle(3);
        chk({n, "_count"}, 72'(got.size()), 72'(nwin));
        chk({n, "_drain"}, 72'(exp_q.size()), 72'd0);
        chk({n, "_fd"}, 72'(seen_fd), 72'(exp_fd));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a window.
    always @(negedge clk) begin
        if (win_valid) begin
            got.push_back(win);
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_win got %h expected none", win);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("win", win, e.w);
                chk("frame_done", 72'(frame_done), 72'(e.fd));
            end
        end else if (frame_done) begin
            n_cmp++; n_err++;
            $display("FAIL stray_frame_done got 1 expected 0");
        end
        if (frame_done) seen_fd++;
        if (b_wv) big_wv++;
        if (b_fd) big_fd++;
    end

    initial begin
        reset = 1'b1; pixel_in = '0; pixel_valid = 1'b0; sof = 1'b0;
        b_pix = '0; b_valid = 1'b0; b_sof = 1'b0;
        idle(2);
        chk("rst_win", win, 72'd0);
        chk("rst_wv", 72'(win_valid), 72'd0);
        chk("rst_fd", 72'(frame_done), 72'd0);
        reset = 1'b0;
        idle(1);

        // continuous frame
        got.delete();
        frame(0, 20, 1'b0, 1'b0);
        end_test("cont", 6);
        if (got.size() == 6) begin
            chk("cont_first", got[0], 72'h00_01_02_05_06_07_0a_0b_0c);
            chk("cont_last",  got[5], 72'h07_08_09_0c_0d_0e_11_12_13);
        end

        // pixel_valid low every other cycle
        got.delete();
        frame(0, 20, 1'b1, 1'b0);
        end_test("gap", 6);
        if (got.size() == 6) begin
            chk("gap_first", got[0], 72'h00_01_02_05_06_07_0a_0b_0c);
            chk("gap_last",  got[5], 72'h07_08_09_0c_0d_0e_11_12_13);
        end

        // back-to-back frames
        got.delete();
        frame(0, 20, 1'b0, 1'b0);
        frame(100, 20, 1'b0, 1'b0);
        end_test("b2b", 12);
        if (got.size() == 12)
            chk("b2b_f2_first", got[6], 72'h64_65_66_69_6a_6b_6e_6f_70);

        // sof restarts a frame abandoned in FILL
        got.delete();
        frame(50, 8, 1'b0, 1'b0);
        frame(0, 20, 1'b0, 1'b1);
        end_test("sof8", 6);
        if (got.size() == 6) begin
            chk("sof8_first", got[0], 72'h00_01_02_05_06_07_0a_0b_0c);
            chk("sof8_last",  got[5], 72'h07_08_09_0c_0d_0e_11_12_13);
        end

        // sof restarts a frame abandoned in STREAM (2 windows from the old frame)
        got.delete();
        frame(50, 14, 1'b0, 1'b0);
        frame(0, 20, 1'b0, 1'b1);
        end_test("sof14", 8);
        if (got.size() == 8)
            chk("sof14_first_new", got[2], 72'h00_01_02_05_06_07_0a_0b_0c);

        // reset mid-frame after pixel 14
        got.delete();
        frame(0, 15, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("pre_rst_win", win, 72'h02_03_04_07_08_09_0c_0d_0e);
        reset = 1'b1;
        #1;
        chk("mid_rst_win", win, 72'd0);
        chk("mid_rst_wv", 72'(win_valid), 72'd0);
        chk("mid_rst_fd", 72'(frame_done), 72'd0);
        idle(2);
        chk("mid_rst_win_hold", win, 72'd0);
        reset = 1'b0;
        m_r = 0; m_c = 0;
        frame(0, 20, 1'b0, 1'b0);
        end_test("rst", 9);
        if (got.size() == 9) begin
            chk("rst_first", got[3], 72'h00_01_02_05_06_07_0a_0b_0c);
            chk("rst_last",  got[8], 72'h07_08_09_0c_0d_0e_11_12_13);
        end

        // default parameters, one full frame
        for (int k = 0; k < 31250; k++) begin
            b_pix = 8'($urandom); b_valid = 1'b1;
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        idle(3);
        chk("big_windows", 72'(big_wv), 72'd30504);
        chk("big_frame_done", 72'(big_fd), 72'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
